cv_layer_sequencer: RTL
=======================

CV_LAYER_SEQUENCER -- requirements
Module: cv_layer_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst (rst low = reset asserted).
REQ-002 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  async active-low reset
- cfg_valid  in  1  layer descriptor offered
- cfg_ready  out  1  descriptor accepted when cfg_valid&cfg_ready
- cfg_K, cfg_Iext, cfg_Oext, cfg_Hext, cfg_Wext  in  5/11/11/8/8  layer geometry
- cfg_has_bias, cfg_act_type, cfg_reuse_w  in  1/5/1  bias enable, activation code, skip weight load
- src_valid, src_data  in  1/16  weight+bias then ifmap stream from memory
- src_ready  out  1  stream beat taken
- sink_valid, sink_data  out  1/16  ofmap stream
- sink_ready  in  1  downstream accepts
- core_load_weight, core_load_input, core_store_output  out  1  one-cycle command pulses
- core_din_valid, core_din_data  out  1/16  core input stream
- core_dout_valid, core_dout_data  in  1/16  core output stream
- core_dout_ready  out  1  core output advance
- core_calc_done  in  1  core compute-finished flag, level
- core_has_bias, core_act_type, core_K, core_Iext, core_Oext, core_Hext, core_Wext  out  latched descriptor
- busy  out  1  layer in progress
- layer_done  out  1  one-cycle pulse at end of layer
- cfg_err  out  1  one-cycle pulse on rejected descriptor

Function
REQ-003 States SHALL be IDLE, W_REQ, W_STRM, W_GRD, I_REQ, I_STRM, C_WAIT, O_REQ, O_STRM, O_GRD, DONE.
REQ-004 cfg_ready SHALL be 1 only in IDLE; on accept, all cfg_* SHALL be latched into core_* outputs, which stay constant until the next accept.
REQ-005 A descriptor with K!=3, any extent 0, Hext<3 or Wext<3 SHALL be rejected: cfg_err pulses the cycle after accept, state stays IDLE.
REQ-006 A valid accept SHALL go to W_REQ, or to I_REQ if cfg_reuse_w=1.
REQ-007 W_REQ, I_REQ, O_REQ SHALL last exactly one cycle, asserting core_load_weight, core_load_input, core_store_output respectively.
REQ-008 src_ready SHALL be 1 only in W_STRM and I_STRM; core_din_valid = src_valid&src_ready; core_din_data = src_data.
REQ-009 A 32-bit beat counter SHALL count accepted beats; target in W_STRM = Oext*Iext*K*K (+Oext if has_bias), in I_STRM = Iext*Hext*Wext, in O_STRM = Oext*(Hext-K+1)*(Wext-K+1), all computed in 32 bits.
REQ-010 When the final beat of W_STRM is accepted, the block SHALL enter W_GRD, hold 3 cycles, then go to I_REQ.
REQ-011 The final I_STRM beat SHALL go to C_WAIT; C_WAIT SHALL exit to O_REQ the first cycle core_calc_done=1.
REQ-012 In O_STRM: sink_valid = core_dout_valid; core_dout_ready = sink_ready&core_dout_valid; sink_data = core_dout_data; a beat counts when sink_valid&sink_ready.
REQ-013 Outside O_STRM, sink_valid and core_dout_ready SHALL be 0, even if core_dout_valid=1.
REQ-014 The final O_STRM beat SHALL go to O_GRD (3 cycles), then DONE (1 cycle, layer_done=1), then IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 Stalls SHALL be unbounded: src_valid=0 or sink_ready=0 holds state and counter unchanged.
REQ-017 cfg_valid while not in IDLE SHALL be ignored, with no latch and no error.

Reset
REQ-018 While rst=0: state IDLE, counter 0, all core_* commands/valids 0, latched geometry 0, sink_valid/src_ready/busy/layer_done/cfg_err 0; cfg_ready 1 after release.
REQ-019 Reset mid-layer SHALL abort immediately with no pulse emitted; the core is reset by the same rst net.

Verification
REQ-020 K=3,I=1,O=1,H=W=4,bias=0: 9 weight beats, 1-cycle load_weight pulse, then 3-cycle guard; 16 ifmap beats; calc_done; 4 ofmap beats; layer_done once; busy low after.
REQ-021 Same layer, has_bias=1: exactly 10 beats taken in W_STRM; beat 11 is held with src_ready=0 until I_STRM.
REQ-022 Back-to-back layer with cfg_reuse_w=1: no core_load_weight; first command is core_load_input.
REQ-023 sink_ready toggled 1/0 each cycle during O_STRM: 4 beats transferred, none duplicated; core_dout_valid=1 during O_GRD gives sink_valid=0.
REQ-024 cfg_K=5 -> cfg_err pulses once, busy stays 0; cfg_Hext=0 -> same.
REQ-025 rst=0 asserted in I_STRM after 7 beats -> all outputs reach reset values asynchronously; a new descriptor after release runs from W_REQ.

Source files
------------

// File: rtl/cv_layer_sequencer_if.sv
// Signal bundle between the layer sequencer, the descriptor source, the memory/ofmap streams
// and the convolution core. The sequencer uses the slave view, its environment the master view.
interface cv_layer_sequencer_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [4:0]  cfg_K;
  logic [10:0] cfg_Iext;
  logic [10:0] cfg_Oext;
  logic [7:0]  cfg_Hext;
  logic [7:0]  cfg_Wext;
  logic        cfg_has_bias;
  logic [4:0]  cfg_act_type;
  logic        cfg_reuse_w;

  logic        src_valid;
  logic [15:0] src_data;
  logic        src_ready;

  logic        sink_valid;
  logic [15:0] sink_data;
  logic        sink_ready;

  logic        core_load_weight;
  logic        core_load_input;
  logic        core_store_output;
  logic        core_din_valid;
  logic [15:0] core_din_data;
  logic        core_dout_valid;
  logic [15:0] core_dout_data;
  logic        core_dout_ready;
  logic        core_calc_done;
  logic        core_has_bias;
  logic [4:0]  core_act_type;
  logic [4:0]  core_K;
  logic [10:0] core_Iext;
  logic [10:0] core_Oext;
  logic [7:0]  core_Hext;
  logic [7:0]  core_Wext;

  logic        busy;
  logic        layer_done;
  logic        cfg_err;

  modport slave (
    input  cfg_valid, cfg_K, cfg_Iext, cfg_Oext, cfg_Hext, cfg_Wext,
           cfg_has_bias, cfg_act_type, cfg_reuse_w,
           src_valid, src_data, sink_ready,
           core_dout_valid, core_dout_data, core_calc_done,
    output cfg_ready, src_ready, sink_valid, sink_data,
           core_load_weight, core_load_input, core_store_output,
           core_din_valid, core_din_data, core_dout_ready,
           core_has_bias, core_act_type, core_K, core_Iext, core_Oext, core_Hext, core_Wext,
           busy, layer_done, cfg_err
  );

  modport master (
    output cfg_valid, cfg_K, cfg_Iext, cfg_Oext, cfg_Hext, cfg_Wext,
           cfg_has_bias, cfg_act_type, cfg_reuse_w,
           src_valid, src_data, sink_ready,
           core_dout_valid, core_dout_data, core_calc_done,
    input  cfg_ready, src_ready, sink_valid, sink_data,
           core_load_weight, core_load_input, core_store_output,
           core_din_valid, core_din_data, core_dout_ready,
           core_has_bias, core_act_type, core_K, core_Iext, core_Oext, core_Hext, core_Wext,
           busy, layer_done, cfg_err
  );
endinterface

// File: rtl/cv_layer_sequencer.sv
// Layer sequencer for a 3x3 convolution core: takes one layer descriptor, streams weights and
// the input feature map into the core, waits for compute, then drains the output feature map.
module cv_layer_sequencer (
  input  logic                 clk,
  input  logic                 rst,
  cv_layer_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    W_REQ  = 4'd1,
    W_STRM = 4'd2,
    W_GRD  = 4'd3,
    I_REQ  = 4'd4,
    I_STRM = 4'd5,
    C_WAIT = 4'd6,
    O_REQ  = 4'd7,
    O_STRM = 4'd8,
    O_GRD  = 4'd9,
    DONE   = 4'd10
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] beat_cnt_r;
  logic [1:0]  grd_cnt_r;
  logic        cfg_err_r;
  logic [4:0]  k_r;
  logic [10:0] iext_r;
  logic [10:0] oext_r;
  logic [7:0]  hext_r;
  logic [7:0]  wext_r;
  logic        bias_r;
  logic [4:0]  act_r;

  logic        accept_s;
  logic        cfg_ok_s;
  logic        src_ready_s;
  logic        o_strm_s;
  logic        beat_s;
  logic        last_beat_s;
  logic        guard_s;
  logic        guard_end_s;
  logic [31:0] k32_s;
  logic [31:0] i32_s;
  logic [31:0] o32_s;
  logic [31:0] h32_s;
  logic [31:0] w32_s;
  logic [31:0] w_target_s;
  logic [31:0] i_target_s;
  logic [31:0] o_target_s;
  logic [31:0] target_s;

  assign accept_s = bus.cfg_valid & (state_r == IDLE);
  assign cfg_ok_s = (bus.cfg_K == 5'd3) && (bus.cfg_Iext != 11'd0) && (bus.cfg_Oext != 11'd0)
                    && (bus.cfg_Hext >= 8'd3) && (bus.cfg_Wext >= 8'd3);

  // All beat targets are formed in 32 bits from the latched geometry.
  assign k32_s      = {27'd0, k_r};
  assign i32_s      = {21'd0, iext_r};
  assign o32_s      = {21'd0, oext_r};
  assign h32_s      = {24'd0, hext_r};
  assign w32_s      = {24'd0, wext_r};
  assign w_target_s = o32_s * i32_s * k32_s * k32_s + (bias_r ? o32_s : 32'd0);
  assign i_target_s = i32_s * h32_s * w32_s;
  assign o_target_s = o32_s * (h32_s - k32_s + 32'd1) * (w32_s - k32_s + 32'd1);

  assign src_ready_s = (state_r == W_STRM) || (state_r == I_STRM);
  assign o_strm_s    = (state_r == O_STRM);
  assign beat_s      = src_ready_s ? bus.src_valid
                                   : (o_strm_s & bus.core_dout_valid & bus.sink_ready);
  assign last_beat_s = beat_s && ((beat_cnt_r + 32'd1) == target_s);
  assign guard_s     = (state_r == W_GRD) || (state_r == O_GRD);
  assign guard_end_s = guard_s && (grd_cnt_r == 2'd2);

  // Beat target of the stream phase currently active.
  always_comb begin
    target_s = 32'd0;
    case (state_r)
      W_STRM:  target_s = w_target_s;
      I_STRM:  target_s = i_target_s;
      O_STRM:  target_s = o_target_s;
      default: target_s = 32'd0;
    endcase
  end

  // Next-state logic of the layer FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && cfg_ok_s) begin
          state_next_s = bus.cfg_reuse_w ? I_REQ : W_REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      W_REQ:   state_next_s = W_STRM;
      W_STRM:  state_next_s = last_beat_s ? W_GRD : W_STRM;
      W_GRD:   state_next_s = guard_end_s ? I_REQ : W_GRD;
      I_REQ:   state_next_s = I_STRM;
      I_STRM:  state_next_s = last_beat_s ? C_WAIT : I_STRM;
      C_WAIT:  state_next_s = bus.core_calc_done ? O_REQ : C_WAIT;
      O_REQ:   state_next_s = O_STRM;
      O_STRM:  state_next_s = last_beat_s ? O_GRD : O_STRM;
      O_GRD:   state_next_s = guard_end_s ? DONE : O_GRD;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Beat and guard counters; a stall leaves both untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt_r <= 32'd0;
      grd_cnt_r  <= 2'd0;
    end else begin
      if (last_beat_s) begin
        beat_cnt_r <= 32'd0;
      end else if (beat_s) begin
        beat_cnt_r <= beat_cnt_r + 32'd1;
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
      grd_cnt_r <= (guard_s && !guard_end_s) ? (grd_cnt_r + 2'd1) : 2'd0;
    end
  end

  // Descriptor latch and rejection flag; even a rejected descriptor is latched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_r       <= 5'd0;
      iext_r    <= 11'd0;
      oext_r    <= 11'd0;
      hext_r    <= 8'd0;
      wext_r    <= 8'd0;
      bias_r    <= 1'b0;
      act_r     <= 5'd0;
      cfg_err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        k_r    <= bus.cfg_K;
        iext_r <= bus.cfg_Iext;
        oext_r <= bus.cfg_Oext;
        hext_r <= bus.cfg_Hext;
        wext_r <= bus.cfg_Wext;
        bias_r <= bus.cfg_has_bias;
        act_r  <= bus.cfg_act_type;
      end
      cfg_err_r <= accept_s & ~cfg_ok_s;
    end
  end

  // cfg_ready is held low while reset is applied.
  assign bus.cfg_ready         = (state_r == IDLE) & rst;
  assign bus.src_ready         = src_ready_s;
  assign bus.core_din_valid    = bus.src_valid & src_ready_s;
  assign bus.core_din_data     = bus.src_data;
  assign bus.sink_valid        = o_strm_s & bus.core_dout_valid;
  assign bus.sink_data         = bus.core_dout_data;
  assign bus.core_dout_ready   = o_strm_s & bus.core_dout_valid & bus.sink_ready;
  assign bus.core_load_weight  = (state_r == W_REQ);
  assign bus.core_load_input   = (state_r == I_REQ);
  assign bus.core_store_output = (state_r == O_REQ);
  assign bus.core_K            = k_r;
  assign bus.core_Iext         = iext_r;
  assign bus.core_Oext         = oext_r;
  assign bus.core_Hext         = hext_r;
  assign bus.core_Wext         = wext_r;
  assign bus.core_has_bias     = bias_r;
  assign bus.core_act_type     = act_r;
  assign bus.busy              = (state_r != IDLE);
  assign bus.layer_done        = (state_r == DONE);
  assign bus.cfg_err           = cfg_err_r;

endmodule
